// File: rtl/apb_uart_tx.sv
// APB-programmable UART transmitter with a one-byte transmit buffer.
// Register map: 0 status (RO), 1 error (RO, clear on read), 2/3 bit period,
// 4 data size, 6 transmit data. Frames are start bit, data LSB first, stop bit.
module apb_uart_tx (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [2:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pslverr,
    output logic       serial_out,
    output logic [1:0] tx_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]  state;
    logic [13:0] bit_period;
    logic [13:0] period_l;
    logic [13:0] bit_tmr;
    logic [3:0]  data_size;
    logic [3:0]  size_l;
    logic [3:0]  bit_cnt;
    logic [7:0]  tx_data;
    logic [7:0]  shift;
    logic        buffer_full;
    logic        overrun;
    logic        bad;
    logic        access;
    logic        wr_en;
    logic        tx_wr;
    logic        err_rd;
    logic        tx_busy;
    logic        bit_end;
    logic        load;

    // Handshake: an APB transfer completes in the single cycle where psel and
    // penable are both high (no wait states); the setup cycle (penable=0) has
    // no side effects. prdata is valid whenever psel=1 and pwrite=0.
    assign access  = psel & penable;
    assign pslverr = access & bad;
    assign wr_en   = access & pwrite & ~bad;
    assign tx_wr   = wr_en & (paddr == 3'd6);
    assign err_rd  = access & ~pwrite & (paddr == 3'd1);
    assign tx_busy = (state != S_IDLE);
    assign bit_end = (bit_tmr == period_l - 14'd1);
    // A buffered byte starts a frame from IDLE or straight out of the stop bit.
    assign load    = buffer_full & ((state == S_IDLE) | ((state == S_STOP) & bit_end));
    assign tx_state = state;

    // Decode illegal addresses, writes to read-only registers and bad data sizes.
    always_comb begin
        bad = 1'b0;
        if (paddr == 3'd5 || paddr == 3'd7)
            bad = 1'b1;
        else if (pwrite && (paddr == 3'd0 || paddr == 3'd1))
            bad = 1'b1;
        else if (pwrite && paddr == 3'd4 &&
                 !(pwdata == 8'd5 || pwdata == 8'd7 || pwdata == 8'd8))
            bad = 1'b1;
    end

    // Read mux; returns zero whenever no read is selected.
    always_comb begin
        prdata = 8'h00;
        if (psel && !pwrite) begin
            case (paddr)
                3'd0:    prdata = {6'b0, buffer_full, tx_busy};
                3'd1:    prdata = {7'b0, overrun};
                3'd2:    prdata = bit_period[7:0];
                3'd3:    prdata = {2'b0, bit_period[13:8]};
                3'd4:    prdata = {4'b0, data_size};
                3'd6:    prdata = tx_data;
                default: prdata = 8'h00;
            endcase
        end
    end

    // Configuration registers, transmit buffer and overrun flag.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            bit_period  <= 14'd10;
            data_size   <= 4'd8;
            tx_data     <= 8'h00;
            buffer_full <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (wr_en) begin
                case (paddr)
                    3'd2:    bit_period[7:0]  <= pwdata;
                    3'd3:    bit_period[13:8] <= pwdata[5:0];
                    3'd4:    data_size        <= pwdata[3:0];
                    default: ;
                endcase
            end
            // A write into a full buffer is dropped; the buffered byte stays.
            if (tx_wr && !buffer_full)
                tx_data <= pwdata;
            if (load)
                buffer_full <= 1'b0;
            else if (tx_wr)
                buffer_full <= 1'b1;
            // A new overrun wins over a simultaneous clearing read.
            if (tx_wr && buffer_full)
                overrun <= 1'b1;
            else if (err_rd)
                overrun <= 1'b0;
        end
    end

    // Transmit FSM: per-state bit timer and data bit counter.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= S_IDLE;
            bit_tmr  <= 14'd0;
            bit_cnt  <= 4'd0;
            shift    <= 8'h00;
            period_l <= 14'd2;
            size_l   <= 4'd8;
        end else if (load) begin
            state    <= S_START;
            bit_tmr  <= 14'd0;
            bit_cnt  <= 4'd0;
            shift    <= tx_data;
            period_l <= (bit_period < 14'd2) ? 14'd2 : bit_period;
            size_l   <= data_size;
        end else begin
            case (state)
                S_START: begin
                    if (bit_end) begin
                        state   <= S_DATA;
                        bit_tmr <= 14'd0;
                        bit_cnt <= 4'd0;
                    end else begin
                        bit_tmr <= bit_tmr + 14'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        bit_tmr <= 14'd0;
                        if (bit_cnt == size_l - 4'd1) begin
                            state   <= S_STOP;
                            bit_cnt <= 4'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            shift   <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        bit_tmr <= bit_tmr + 14'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        state   <= S_IDLE;
                        bit_tmr <= 14'd0;
                        bit_cnt <= 4'd0;
                    end else begin
                        bit_tmr <= bit_tmr + 14'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered line driver; follows the FSM state one cycle later.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            serial_out <= 1'b1;
        end else begin
            case (state)
                S_START: serial_out <= 1'b0;
                S_DATA:  serial_out <= shift[0];
                default: serial_out <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_tx.sv
// Testbench for apb_uart_tx: directed scenarios plus randomized APB traffic,
// checked against a frame-level reference model of registers and line timing.
module tb_apb_uart_tx;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [2:0] paddr = 3'd0;
  logic [7:0] pwdata = 8'h00;
  logic [7:0] prdata;
  logic       pslverr;
  logic       serial_out;
  logic [1:0] tx_state;

  apb_uart_tx dut (
    .clk(clk), .n_rst(n_rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pslverr(pslverr),
    .serial_out(serial_out), .tx_state(tx_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam int MAXC = 32768;
  logic        line_exp [0:MAXC-1];
  int          cyc = 0;
  int          free_edge = 0;
  logic        m_full = 1'b0;
  logic        m_ovr = 1'b0;
  logic [7:0]  m_txd = 8'h00;
  logic [13:0] m_bp = 14'd10;
  logic [3:0]  m_ds = 4'd8;

  int n_cmp = 0;
  int n_bad = 0;

  initial begin
    for (int i = 0; i < MAXC; i++) line_exp[i] = 1'b1;
  end

  function automatic logic exp_err(input logic w, input logic [2:0] a, input logic [7:0] d);
    if (a == 3'd5 || a == 3'd7) return 1'b1;
    if (w && (a == 3'd0 || a == 3'd1)) return 1'b1;
    if (w && a == 3'd4 && !(d == 8'd5 || d == 8'd7 || d == 8'd8)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] exp_rd(input logic [2:0] a);
    logic busy;
    busy = (cyc < free_edge);
    case (a)
      3'd0: return {6'b0, m_full, busy};
      3'd1: return {7'b0, m_ovr};
      3'd2: return m_bp[7:0];
      3'd3: return {2'b0, m_bp[13:8]};
      3'd4: return {4'b0, m_ds};
      3'd6: return m_txd;
      default: return 8'h00;
    endcase
  endfunction

  // Model advance at every rising edge: a buffered byte starts a frame as soon
  // as the previous frame has fully ended; the frame is laid out on the
  // expected-line timeline starting one cycle after the load edge.
  always @(posedge clk) begin
    logic acc;
    logic err;
    logic full_pre;
    logic v;
    int   bp;
    int   nb;
    int   len;
    int   slot;
    cyc++;
    if (!n_rst) begin
      for (int k = cyc; k <= free_edge && k < MAXC; k++) line_exp[k] = 1'b1;
      free_edge = 0;
      m_full = 1'b0;
      m_ovr = 1'b0;
      m_txd = 8'h00;
      m_bp = 14'd10;
      m_ds = 4'd8;
    end else begin
      acc = psel && penable;
      err = exp_err(pwrite, paddr, pwdata);
      full_pre = m_full;
      if (full_pre && cyc >= free_edge) begin
        bp = (m_bp < 14'd2) ? 2 : int'(m_bp);
        nb = int'(m_ds);
        len = (nb + 2) * bp;
        for (int j = 0; j < len; j++) begin
          slot = j / bp;
          if (slot == 0) v = 1'b0;
          else if (slot <= nb) v = m_txd[slot-1];
          else v = 1'b1;
          if (cyc + 1 + j < MAXC) line_exp[cyc + 1 + j] = v;
        end
        free_edge = cyc + len;
        m_full = 1'b0;
      end
      if (acc && pwrite && !err) begin
        case (paddr)
          3'd2: m_bp[7:0] = pwdata;
          3'd3: m_bp[13:8] = pwdata[5:0];
          3'd4: m_ds = pwdata[3:0];
          3'd6: begin
            if (!full_pre) begin
              m_txd = pwdata;
              m_full = 1'b1;
            end else begin
              m_ovr = 1'b1;
            end
          end
          default: ;
        endcase
      end else if (acc && !pwrite && paddr == 3'd1) begin
        m_ovr = 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Per-cycle monitor: line level against the model timeline, idle bus outputs.
  always @(negedge clk) begin
    #3;
    check("serial_out", serial_out, line_exp[cyc]);
    if (!psel) begin
      check("idle_prdata", prdata, 8'h00);
      check("idle_pslverr", pslverr, 1'b0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apb(input logic w, input logic [2:0] a, input logic [7:0] d,
                     output logic [7:0] rd, output logic er);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    #1;
    rd = prdata;
    er = pslverr;
    check("pslverr", er, exp_err(w, a, d));
    check("prdata", rd, w ? 8'h00 : exp_rd(a));
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] v;
    logic e;
    apb(1'b1, a, d, v, e);
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] v);
    logic e;
    apb(1'b0, a, 8'h00, v, e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    logic [7:0] v;
    int start;
    start = cyc;
    v = 8'hff;
    while (v != 8'h00 && cyc - start < budget) rd(3'd0, v);
    check("idle_timeout", v, 8'h00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] v;
    logic       e;
    logic [2:0] a;
    logic       w;
    logic [7:0] d;
    logic [7:0] ds_opts [6];
    ds_opts = '{8'd5, 8'd7, 8'd8, 8'd3, 8'd0, 8'd15};

    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;

    // Reset values
    rd(3'd0, v); check("rst_status", v, 8'h00);
    rd(3'd1, v); check("rst_error", v, 8'h00);
    rd(3'd2, v); check("rst_bp_lo", v, 8'd10);
    rd(3'd3, v); check("rst_bp_hi", v, 8'd0);
    rd(3'd4, v); check("rst_dsize", v, 8'd8);
    rd(3'd6, v); check("rst_txdata", v, 8'h00);

    // Default frame of 0xA5
    wr(3'd6, 8'hA5);
    wait_idle(400);

    // Five data bits, bit period 4, upper data bits ignored
    wr(3'd4, 8'd5);
    wr(3'd2, 8'd4);
    wr(3'd6, 8'hE0);
    wait_idle(200);
    wr(3'd4, 8'd8);
    wr(3'd2, 8'd10);

    // Back-to-back frames
    wr(3'd6, 8'h55);
    idle(20);
    wr(3'd6, 8'h0F);
    rd(3'd0, v); check("b2b_status_full", v, 8'h03);
    idle(90);
    rd(3'd0, v); check("b2b_status_loaded", v, 8'h01);
    wait_idle(600);

    // Overrun: third write in one frame is dropped
    wr(3'd6, 8'h11);
    idle(5);
    wr(3'd6, 8'h22);
    wr(3'd6, 8'h33);
    rd(3'd1, v); check("ovr_set", v, 8'h01);
    rd(3'd1, v); check("ovr_cleared", v, 8'h00);
    rd(3'd6, v); check("ovr_kept_byte", v, 8'h22);
    wait_idle(600);

    // Error responses leave state unchanged
    apb(1'b1, 3'd0, 8'h12, v, e); check("err_wr_status", e, 1'b1);
    apb(1'b0, 3'd7, 8'h00, v, e); check("err_rd_addr7", e, 1'b1);
    apb(1'b1, 3'd4, 8'd6, v, e);  check("err_dsize6", e, 1'b1);
    rd(3'd4, v); check("dsize_unchanged", v, 8'h08);

    // Reset in the middle of the data bits drops the frame
    wr(3'd6, 8'hC3);
    idle(30);
    pulse_reset();
    rd(3'd0, v); check("rst_mid_status", v, 8'h00);
    idle(150);

    // Randomized traffic with random gaps and occasional resets
    for (int i = 0; i < 80; i++) begin
      a = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      case (a)
        3'd2: d = 8'($urandom_range(0, 12));
        3'd3: d = 8'($urandom_range(0, 3) << 6);
        3'd4: d = ds_opts[$urandom_range(0, 5)];
        default: d = 8'($urandom_range(0, 255));
      endcase
      apb(w, a, d, v, e);
      if ($urandom_range(0, 29) == 0) pulse_reset();
      idle($urandom_range(0, 30));
    end
    wait_idle(2000);
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_uart_tx.md
APB_UART_TX -- requirements
Module: apb_uart_tx

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state updates on the rising edge.
REQ-002 SHALL have port n_rst, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port psel, input, 1 bit: APB select.
REQ-004 SHALL have port penable, input, 1 bit: APB access phase.
REQ-005 SHALL have port pwrite, input, 1 bit: 1 = write, 0 = read.
REQ-006 SHALL have port paddr, input, 3 bits: register address.
REQ-007 SHALL have port pwdata, input, 8 bits: write data.
REQ-008 SHALL have port prdata, output, 8 bits: read data.
REQ-009 SHALL have port pslverr, output, 1 bit: access error.
REQ-010 SHALL have port serial_out, output, 1 bit: UART line; idles high.

Function
REQ-011 SHALL complete an APB access in the cycle with psel=1 and penable=1, with zero wait states; penable=0 cycles have no effect.
REQ-012 SHALL use this register map:
- 0: status, RO; bit0 = tx_busy, bit1 = buffer_full.
- 1: error, RO; bit0 = overrun; cleared by a read.
- 2: bit_period[7:0], RW.
- 3: bit_period[13:8], RW; upper bits read 0.
- 4: data_size[3:0], RW.
- 6: tx_data, RW; reads return the last written byte.
REQ-013 SHALL drive prdata combinationally while psel=1 and pwrite=0, and drive 0 otherwise.
REQ-014 SHALL assert pslverr combinationally during an access for any of: address 5 or 7; write to address 0 or 1; write to address 4 with a value not in {5,7,8}. Erroring writes change no state.
REQ-015 SHALL reset bit_period to 10 and data_size to 8.
REQ-016 SHALL set buffer_full one cycle after a tx_data write when buffer_full=0.
REQ-017 SHALL, on a tx_data write while buffer_full=1, discard the new byte, keep the buffered byte, and set overrun.
REQ-018 SHALL, if a read of address 1 and an overrun event occur in the same cycle, leave overrun=1.
REQ-019 SHALL implement a transmit FSM with states IDLE, START, DATA, STOP.
REQ-020 SHALL, in IDLE with buffer_full=1, do the following on the next edge:
- load the shift register;
- latch bit_period (values <2 clamped to 2) and data_size;
- clear buffer_full;
- enter START.
REQ-021 SHALL hold serial_out=0 in START for exactly the latched bit_period cycles.
REQ-022 SHALL, in DATA, send the low data_size bits LSB first, each for bit_period cycles.
REQ-023 SHALL hold serial_out=1 in STOP for bit_period cycles.
REQ-024 SHALL make a full frame last (data_size+2)*bit_period cycles.
REQ-025 SHALL, at the end of STOP, enter START directly if buffer_full=1 (no idle cycle), else enter IDLE.
REQ-026 SHALL assert tx_busy in every state except IDLE.
REQ-027 SHALL let configuration writes during a frame affect only later frames.
REQ-028 SHALL allow a tx_data write during a frame to fill the buffer normally.
REQ-029 SHALL make a tx_data write first visible on serial_out (start bit low) two edges after the write edge when starting from IDLE.
REQ-030 SHALL use a 14-bit bit-timer and a 4-bit bit counter, both cleared at each state entry.

Reset
REQ-031 SHALL, when n_rst=0 at a rising edge, set the FSM to IDLE and the following, on that edge:
- serial_out = 1;
- buffer_full = 0, overrun = 0;
- tx_data = 0;
- timers = 0;
- bit_period = 10, data_size = 8.
REQ-032 SHALL, on reset during a frame, drop the frame: serial_out=1 from the next cycle, no partial resumption.
REQ-033 SHALL hold prdata=0 and pslverr=0 while psel=0, including during reset.

Verification
REQ-034 SHALL cover: defaults, write tx_data=0xA5 -> line low for 10 cycles, then bits 1,0,1,0,0,1,0,1, then high for 10 cycles; 100-cycle frame; tx_busy=0 afterwards.
REQ-035 SHALL cover: data_size=5, bit_period=4, write 0xE0 -> 0 for 4 cycles, five 0 bits, stop for 4 cycles; 28 cycles total; upper bits ignored.
REQ-036 SHALL cover: write 0x55, then 0x0F mid-frame -> second start bit on the cycle after the first stop ends; status reads 0x03 between the writes, 0x01 after the second frame loads.
REQ-037 SHALL cover: three writes during one frame -> third dropped; address 1 reads 0x01, then 0x00; only two frames sent.
REQ-038 SHALL cover: write address 0, read address 7, write data_size=6 -> pslverr=1 each; address 4 still reads 0x08.
REQ-039 SHALL cover: n_rst=0 for 1 cycle mid-DATA -> serial_out=1 next cycle; status=0x00; no further frame.
